mem_stall_ctrl: RTL

//   M-stage data-memory access controller; the stall-requesting end of the hazard/stall interface.

---
 rtl/mem_stall_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl
//   M-stage data-memory access controller. Accepts a load/store from the M
//   stage, runs a req/ack handshake with a multi-cycle data memory and holds
//   StallReqM until the access completes. Applies byte enables and store lane
//   replication, and extends load data. A misaligned or illegal op faults
//   immediately with no bus request. A request that gets no ack within
//   TIMEOUT cycles is aborted with a bus error.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     MemReqM, MemWriteM       M stage holds a load/store; 1 = store
//     funct3M, AddrM           width/sign code, byte address
//     WriteDataM               right-aligned store data
//     ReadDataM                extended load data, valid in DONE
//     StallReqM, BubbleW       stall F/D/E/M, flush W (same signal)
//     MemFaultM                one-cycle fault pulse
//     mem_req/we/addr/wdata/be registered memory request
//     mem_ack, mem_rdata       memory completion pulse and read word
module mem_stall_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallReqM,
    output logic        BubbleW,
    output logic        MemFaultM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     f3_q;      // width/sign of the access in flight
    logic [1:0]     off_q;     // byte offset of the access in flight
    logic           tmo_q;     // access ended by timeout; fault shows in DONE

    logic           op_fault, accept, tmo_hit;
    logic [3:0]     be;
    logic [31:0]    wdata, lane, ld_ext;

    // Fault check on the live M-stage inputs
    always_comb begin
        op_fault = (funct3M[1:0] == 2'b11) || (funct3M == 3'b110)
                || ((funct3M[1:0] == 2'b01) && AddrM[0])
                || ((funct3M[1:0] == 2'b10) && (AddrM[1:0] != 2'b00));
    end

    assign accept  = (state_q == IDLE) && MemReqM && !op_fault;
    assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));

    // Byte enables and lane-replicated store data
    always_comb begin
        be    = 4'b1111;
        wdata = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                be    = 4'b0001 << AddrM[1:0];
                wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be    = AddrM[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and extension, from the registered access attributes
    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{24{lane[7]}},  lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {24'd0, lane[7:0]};
            3'b101:  ld_ext = {16'd0, lane[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Next state and the combinational pipeline-control outputs.
    // The accepting IDLE cycle already stalls, so a 1-cycle ack costs
    // exactly two stall cycles. Outputs are forced quiet while in reset.
    always_comb begin
        state_d   = state_q;
        StallReqM = 1'b0;
        MemFaultM = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ:  if (mem_ack || tmo_hit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            StallReqM = accept || (state_q == REQ);
            MemFaultM = ((state_q == IDLE) && MemReqM && op_fault)
                     || ((state_q == DONE) && tmo_q);
        end
    end

    assign BubbleW = StallReqM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            tmo_q     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            ReadDataM <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (accept) begin
                    mem_req   <= 1'b1;
                    mem_we    <= MemWriteM;
                    mem_addr  <= {AddrM[31:2], 2'b00};
                    mem_wdata <= wdata;
                    mem_be    <= be;
                    f3_q      <= funct3M;
                    off_q     <= AddrM[1:0];
                    cnt_q     <= '0;
                    tmo_q     <= 1'b0;
                end
                REQ: begin
                    // An ack on the final allowed cycle still completes normally
                    if (mem_ack) begin
                        ReadDataM <= ld_ext;
                        mem_req   <= 1'b0;
                    end else if (tmo_hit) begin
                        ReadDataM <= '0;
                        tmo_q     <= 1'b1;
                        mem_req   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
